// File: rtl/decode_group_queue.sv
// N-lane decode group queue: picks the oldest mispredicting lane for a fetch redirect,
// squashes younger lanes, and buffers surviving groups in a DEPTH-entry FIFO.
module decode_group_queue #(
    parameter int LANES      = 2,
    parameter int UOP_W      = 96,
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = 4,
    localparam int LANE_W    = (LANES > 1) ? $clog2(LANES) : 1,
    localparam int CNT_W     = $clog2(DEPTH + 1),
    localparam int PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        flush,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [LANES-1:0]            in_lane_valid,
    input  logic [LANES*UOP_W-1:0]      in_uop,
    input  logic [LANES-1:0]            in_mispredict,
    input  logic [LANES*ADDR_WIDTH-1:0] in_new_pc,
    output logic                        fb_valid,
    output logic [ADDR_WIDTH-1:0]       fb_new_pc,
    output logic [LANE_W-1:0]           fb_lane,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [LANES-1:0]            out_lane_valid,
    output logic [LANES*UOP_W-1:0]      out_uop,
    output logic [CNT_W-1:0]            count
);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_C  = PTR_W'(DEPTH - 1);

    logic [LANES*UOP_W-1:0] uop_mem [DEPTH];
    logic [LANES-1:0]       lv_mem  [DEPTH];

    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;

    logic                  accept, enq, deq, found;
    logic [LANES-1:0]      lv_squashed;
    logic [ADDR_WIDTH-1:0] sel_pc;
    logic [LANE_W-1:0]     sel_lane;

    assign out_valid = (count_q != '0);
    assign in_ready  = (count_q < DEPTH_C) || (out_valid && out_ready);
    // Reset is folded in so no redirect escapes while the queue is held in reset.
    assign accept    = in_valid && in_ready && !flush && !reset;
    assign enq       = accept && (lv_squashed != '0);
    assign deq       = out_valid && out_ready && !flush;
    assign count     = count_q;

    // Walk lanes oldest-first; a lane survives only if no older lane redirected.
    // NOTE: always_comb gives every output a default first, so no latch is inferred.
    always_comb begin
        found       = 1'b0;
        sel_pc      = '0;
        sel_lane    = '0;
        lv_squashed = '0;
        for (int i = 0; i < LANES; i++) begin
            lv_squashed[i] = in_lane_valid[i] && !found;
            if (!found && in_lane_valid[i] && in_mispredict[i]) begin
                found    = 1'b1;
                sel_pc   = in_new_pc[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_lane = LANE_W'(i);
            end
        end
    end

    assign fb_valid  = accept && found;
    assign fb_new_pc = fb_valid ? sel_pc : '0;
    assign fb_lane   = fb_valid ? sel_lane : '0;

    assign out_uop        = out_valid ? uop_mem[rd_ptr_q] : '0;
    assign out_lane_valid = out_valid ? lv_mem[rd_ptr_q] : '0;

    always_comb begin
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (flush) begin
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            if (enq) wr_ptr_d = (wr_ptr_q == LAST_C) ? '0 : wr_ptr_q + 1'b1;
            if (deq) rd_ptr_d = (rd_ptr_q == LAST_C) ? '0 : rd_ptr_q + 1'b1;
            if (enq && !deq)      count_d = count_q + 1'b1;
            else if (!enq && deq) count_d = count_q - 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
        end else begin
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

    // NOTE: storage is not reset; empty entries are masked by out_valid on the read side.
    always_ff @(posedge clk) begin
        if (enq) begin
            uop_mem[wr_ptr_q] <= in_uop;
            lv_mem[wr_ptr_q]  <= lv_squashed;
        end
    end

endmodule
